// File: rtl/rv32v_types_pkg.sv
// Shared RV32V vector types: SEW/LMUL encodings, sequencer state and element descriptor.
// The optional RV32V_SEQ_MASK_EN build adds v0 masking to the element sequencer.
package rv32v_types_pkg;

    localparam int unsigned VLEN           = 128;
    localparam int unsigned VLEN_WIDTH     = $clog2(VLEN);
    localparam int unsigned VL_CNT_WIDTH   = VLEN_WIDTH + 1;
    localparam int unsigned ELEM_IDX_WIDTH = VLEN_WIDTH;
    localparam int unsigned REG_OFF_WIDTH  = 3;
    localparam int unsigned BYTE_OFF_WIDTH = $clog2(VLEN / 8);

    typedef enum logic [2:0] {
        SEW8  = 3'd0,
        SEW16 = 3'd1,
        SEW32 = 3'd2,
        SEW64 = 3'd3
    } sew_t;

    typedef enum logic [2:0] {
        LMUL1      = 3'd0,
        LMUL2      = 3'd1,
        LMUL4      = 3'd2,
        LMUL8      = 3'd3,
        LMULRSVD   = 3'd4,
        LMULEIGHTH = 3'd5,
        LMULFOURTH = 3'd6,
        LMULHALF   = 3'd7
    } vlmul_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE
    } seq_state_t;

    typedef struct packed {
        logic                      active;
        logic [ELEM_IDX_WIDTH-1:0] idx;
        logic [REG_OFF_WIDTH-1:0]  reg_off;
        logic [BYTE_OFF_WIDTH-1:0] byte_off;
    } elem_desc_t;

    // elems_per_reg is a power of two, so divide/modulo reduce to shift/mask.
    function automatic elem_desc_t make_elem_desc(
        input logic                      active,
        input logic [ELEM_IDX_WIDTH-1:0] idx,
        input logic [1:0]                sew_lg
    );
        logic [ELEM_IDX_WIDTH-1:0] in_reg_mask;
        logic [ELEM_IDX_WIDTH-1:0] reg_sel;
        logic [ELEM_IDX_WIDTH-1:0] byte_pos;
        make_elem_desc = '0;
        in_reg_mask    = (ELEM_IDX_WIDTH'(VLEN / 8) >> sew_lg) - ELEM_IDX_WIDTH'(1);
        reg_sel        = idx >> (BYTE_OFF_WIDTH - 32'(sew_lg));
        byte_pos       = (idx & in_reg_mask) << sew_lg;
        if (active) begin
            make_elem_desc.active   = 1'b1;
            make_elem_desc.idx      = idx;
            make_elem_desc.reg_off  = REG_OFF_WIDTH'(reg_sel);
            make_elem_desc.byte_off = BYTE_OFF_WIDTH'(byte_pos);
        end
    endfunction

endpackage

// File: rtl/rv32v_elem_sequencer_if.sv
// Configuration/descriptor bus of the element sequencer; slave = sequencer side.
// vm/v0_mask exist only when RV32V_SEQ_MASK_EN is defined.
interface rv32v_elem_sequencer_if
    import rv32v_types_pkg::*;
#(
    parameter int unsigned NUM_LANES = 2
);
    logic                                      start_valid;
    logic                                      start_ready;
    logic [VL_CNT_WIDTH-1:0]                   vl;
    logic [ELEM_IDX_WIDTH-1:0]                 vstart;
    sew_t                                      sew;
    vlmul_t                                    lmul;
`ifdef RV32V_SEQ_MASK_EN
    logic                                      vm;
    logic [VLEN-1:0]                           v0_mask;
`endif
    logic                                      out_valid;
    logic                                      out_ready;
    logic [NUM_LANES-1:0]                      lane_active;
    logic [NUM_LANES-1:0][ELEM_IDX_WIDTH-1:0]  elem_idx;
    logic [NUM_LANES-1:0][REG_OFF_WIDTH-1:0]   reg_off;
    logic [NUM_LANES-1:0][BYTE_OFF_WIDTH-1:0]  byte_off;
    logic                                      last;
    logic                                      done;
    logic                                      illegal;

    modport master (
        output start_valid, vl, vstart, sew, lmul, out_ready,
`ifdef RV32V_SEQ_MASK_EN
        output vm, v0_mask,
`endif
        input  start_ready, out_valid, lane_active, elem_idx, reg_off, byte_off,
        input  last, done, illegal
    );

    modport slave (
        input  start_valid, vl, vstart, sew, lmul, out_ready,
`ifdef RV32V_SEQ_MASK_EN
        input  vm, v0_mask,
`endif
        output start_ready, out_valid, lane_active, elem_idx, reg_off, byte_off,
        output last, done, illegal
    );

endinterface

// File: rtl/rv32v_vlmax_calc.sv
// Combinational VLMAX and illegal-vtype detection from SEW/LMUL; shared with vsetvl logic.
module rv32v_vlmax_calc
    import rv32v_types_pkg::*;
(
    input  sew_t                    i_sew,
    input  vlmul_t                  i_lmul,
    output logic [VL_CNT_WIDTH-1:0] o_vlmax,
    output logic                    o_illegal
);
    logic [VL_CNT_WIDTH-1:0] w_epr;

    always_comb begin
        w_epr = VL_CNT_WIDTH'(VLEN >> (32'(i_sew) + 3));
        if (i_lmul[2]) begin
            o_vlmax = w_epr >> (4'd8 - 4'(i_lmul));
        end else begin
            o_vlmax = w_epr << i_lmul[1:0];
        end
        o_illegal = (i_sew > SEW32) || (i_lmul == LMULRSVD) || (o_vlmax == '0);
    end

endmodule

// File: rtl/rv32v_elem_sequencer.sv
// Walks the active element range of a vector config, issuing NUM_LANES descriptors per beat.
// Define RV32V_SEQ_MASK_EN to qualify lanes with vm | v0_mask[idx].
module rv32v_elem_sequencer
    import rv32v_types_pkg::*;
#(
    parameter int unsigned NUM_LANES = 2
)
(
    input logic                   CLK,
    input logic                   RST,
    rv32v_elem_sequencer_if.slave bus
);
    seq_state_t              r_state;
    seq_state_t              w_next_state;
    logic [VL_CNT_WIDTH-1:0] r_cursor;
    logic [VL_CNT_WIDTH-1:0] r_cnt;
    logic [1:0]              r_sew_lg;
    logic                    r_illegal;
    logic [VL_CNT_WIDTH-1:0] w_vlmax;
    logic [VL_CNT_WIDTH-1:0] w_cnt;
    logic                    w_cfg_illegal;
    logic                    w_accept;
    logic                    w_empty;
    logic                    w_last;
    logic                    w_handshake;
    logic [VL_CNT_WIDTH-1:0] w_lane_idx [NUM_LANES];
    logic                    w_lane_on  [NUM_LANES];
    elem_desc_t              w_desc     [NUM_LANES];
`ifdef RV32V_SEQ_MASK_EN
    logic                    r_vm;
    logic [VLEN-1:0]         r_v0_mask;
`endif

    rv32v_vlmax_calc u_vlmax_calc (
        .i_sew     (bus.sew),
        .i_lmul    (bus.lmul),
        .o_vlmax   (w_vlmax),
        .o_illegal (w_cfg_illegal)
    );

    assign w_accept    = (r_state == IDLE) && bus.start_valid;
    assign w_cnt       = (bus.vl < w_vlmax) ? bus.vl : w_vlmax;
    assign w_empty     = {1'b0, bus.vstart} >= w_cnt;
    assign w_last      = ({1'b0, r_cursor} + (VL_CNT_WIDTH + 1)'(NUM_LANES)) >= {1'b0, r_cnt};
    assign w_handshake = (r_state == ISSUE) && bus.out_ready;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Rejected configs reuse DONE for their single-cycle pulse; r_illegal picks which one fires.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = (w_cfg_illegal || w_empty) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (bus.out_ready && w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cursor  <= '0;
            r_cnt     <= '0;
            r_sew_lg  <= '0;
            r_illegal <= 1'b0;
`ifdef RV32V_SEQ_MASK_EN
            r_vm      <= 1'b0;
            r_v0_mask <= '0;
`endif
        end else if (w_accept) begin
            r_cursor  <= VL_CNT_WIDTH'(bus.vstart);
            r_cnt     <= w_cnt;
            r_sew_lg  <= 2'(bus.sew);
            r_illegal <= w_cfg_illegal;
`ifdef RV32V_SEQ_MASK_EN
            r_vm      <= bus.vm;
            r_v0_mask <= bus.v0_mask;
`endif
        end else if (w_handshake) begin
            r_cursor <= r_cursor + VL_CNT_WIDTH'(NUM_LANES);
        end
    end

    always_comb begin
        bus.start_ready = (r_state == IDLE);
        bus.out_valid   = (r_state == ISSUE);
        bus.last        = (r_state == ISSUE) && w_last;
        bus.done        = (r_state == DONE) && !r_illegal;
        bus.illegal     = (r_state == DONE) && r_illegal;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            w_lane_idx[i] = r_cursor + VL_CNT_WIDTH'(i);
            w_lane_on[i]  = (r_state == ISSUE) && (w_lane_idx[i] < r_cnt);
`ifdef RV32V_SEQ_MASK_EN
            w_lane_on[i]  = w_lane_on[i] && (r_vm || r_v0_mask[w_lane_idx[i][ELEM_IDX_WIDTH-1:0]]);
`endif
            w_desc[i]           = make_elem_desc(w_lane_on[i], w_lane_idx[i][ELEM_IDX_WIDTH-1:0], r_sew_lg);
            bus.lane_active[i]  = w_desc[i].active;
            bus.elem_idx[i]     = w_desc[i].idx;
            bus.reg_off[i]      = w_desc[i].reg_off;
            bus.byte_off[i]     = w_desc[i].byte_off;
        end
    end

endmodule

// File: tb/tb_rv32v_elem_sequencer.sv
// Randomized self-checking bench for rv32v_elem_sequencer against a behavioural beat model.
// Mask-specific cases run only when RV32V_SEQ_MASK_EN is defined.
module tb_rv32v_elem_sequencer;
    import rv32v_types_pkg::*;

    localparam int unsigned NL = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rv32v_elem_sequencer_if #(.NUM_LANES(NL)) bus ();

    rv32v_elem_sequencer #(.NUM_LANES(NL)) u_dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    typedef struct {
        logic [NL-1:0]        act;
        logic [NL-1:0][6:0]   idx;
        logic [NL-1:0][2:0]   ro;
        logic [NL-1:0][3:0]   bo;
        logic                 last;
    } beat_t;

    beat_t exp_q[$];

    // Reference: expected beats straight from the element arithmetic of the vector config.
    task automatic build_model(input int vl, input int vstart, input int sew, input int lmul,
                               input bit vm, input logic [127:0] mask, output bit illegal);
        int    sew_bits, epr, vlmax, cnt, e;
        beat_t b;
        sew_bits = 8 << sew;
        epr      = 128 / sew_bits;
        vlmax    = (lmul < 4) ? epr * (1 << lmul) : epr / (1 << (8 - lmul));
        illegal  = (sew > 2) || (lmul == 4) || (vlmax == 0);
        exp_q.delete();
        if (illegal) return;
        cnt = (vl < vlmax) ? vl : vlmax;
        for (int c = vstart; c < cnt; c += NL) begin
            b.act = '0; b.idx = '0; b.ro = '0; b.bo = '0;
            for (int l = 0; l < NL; l++) begin
                e = c + l;
                if (e < cnt && (vm || mask[e])) begin
                    b.act[l] = 1'b1;
                    b.idx[l] = 7'(e);
                    b.ro[l]  = 3'(e / epr);
                    b.bo[l]  = 4'((e % epr) * (sew_bits / 8));
                end
            end
            b.last = (c + NL >= cnt);
            exp_q.push_back(b);
        end
    endtask

    task automatic set_mask(input bit vm, input logic [127:0] mask);
`ifdef RV32V_SEQ_MASK_EN
        bus.vm      = vm;
        bus.v0_mask = mask;
`else
        if (vm && mask[0]) begin end
`endif
    endtask

    task automatic scramble_cfg();
        bus.vl     = 8'($urandom_range(0, 255));
        bus.vstart = 7'($urandom_range(0, 127));
        bus.sew    = sew_t'($urandom_range(0, 7));
        bus.lmul   = vlmul_t'($urandom_range(0, 7));
        set_mask(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom});
    endtask

    task automatic start_cfg(input int vl, input int vstart, input int sew, input int lmul,
                             input bit vm, input logic [127:0] mask);
        @(negedge clk);
        chk("start_ready_idle", bus.start_ready, 1);
        bus.start_valid = 1'b1;
        bus.vl          = 8'(vl);
        bus.vstart      = 7'(vstart);
        bus.sew         = sew_t'(sew);
        bus.lmul        = vlmul_t'(lmul);
        set_mask(vm, mask);
        @(negedge clk);
        scramble_cfg();
        bus.start_valid = 1'($urandom_range(0, 1));
        chk("start_ready_busy", bus.start_ready, 0);
    endtask

    task automatic check_beat(input int beat);
        chk("out_valid",   bus.out_valid,   1);
        chk("lane_active", bus.lane_active, exp_q[beat].act);
        chk("elem_idx",    bus.elem_idx,    exp_q[beat].idx);
        chk("reg_off",     bus.reg_off,     exp_q[beat].ro);
        chk("byte_off",    bus.byte_off,    exp_q[beat].bo);
        chk("last",        bus.last,        exp_q[beat].last);
        chk("done_busy",   bus.done,        0);
    endtask

    task automatic run_cfg(input int vl, input int vstart, input int sew, input int lmul,
                           input bit vm, input logic [127:0] mask,
                           input int ready_pct, input int hold_beat);
        bit ill, rdy;
        int beat, cyc, hold;
        build_model(vl, vstart, sew, lmul, vm, mask, ill);
        start_cfg(vl, vstart, sew, lmul, vm, mask);
        if (ill) begin
            chk("illegal_pulse",    bus.illegal,   1);
            chk("illegal_no_valid", bus.out_valid, 0);
            chk("illegal_no_done",  bus.done,      0);
        end else if (exp_q.size() == 0) begin
            chk("empty_done",     bus.done,      1);
            chk("empty_no_valid", bus.out_valid, 0);
            chk("empty_no_ill",   bus.illegal,   0);
        end else begin
            beat = 0; cyc = 0; hold = 3;
            while (beat < exp_q.size() && cyc < 2000) begin
                check_beat(beat);
                rdy = ($urandom_range(0, 99) < ready_pct);
                if (beat == hold_beat && hold > 0) begin
                    rdy = 1'b0;
                    hold--;
                end
                bus.out_ready   = rdy;
                bus.start_valid = 1'($urandom_range(0, 1));
                scramble_cfg();
                @(negedge clk);
                cyc++;
                if (rdy) beat++;
            end
            if (beat < exp_q.size()) chk("beat_timeout", beat, exp_q.size());
            chk("seq_done",       bus.done,      1);
            chk("done_no_valid",  bus.out_valid, 0);
            chk("done_no_ill",    bus.illegal,   0);
        end
        bus.start_valid = 1'b0;
        @(negedge clk);
        chk("done_cleared",     bus.done,        0);
        chk("illegal_cleared",  bus.illegal,     0);
        chk("start_ready_back", bus.start_ready, 1);
        chk("idle_no_valid",    bus.out_valid,   0);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_out_valid"},   bus.out_valid,   0);
        chk({tag, "_start_ready"}, bus.start_ready, 1);
        chk({tag, "_lane_active"}, bus.lane_active, 0);
        chk({tag, "_elem_idx"},    bus.elem_idx,    0);
        chk({tag, "_reg_off"},     bus.reg_off,     0);
        chk({tag, "_byte_off"},    bus.byte_off,    0);
        chk({tag, "_last"},        bus.last,        0);
        chk({tag, "_done"},        bus.done,        0);
        chk({tag, "_illegal"},     bus.illegal,     0);
    endtask

    task automatic reset_mid_issue();
        bit ill;
        build_model(128, 0, 0, 3, 1'b1, '1, ill);
        start_cfg(128, 0, 0, 3, 1'b1, '1);
        for (int b = 0; b < 3; b++) begin
            check_beat(b);
            bus.out_ready   = 1'b1;
            bus.start_valid = 1'b0;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        check_quiet("rst_mid");
        rst = 1'b0;
        bus.start_valid = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  sew, lmul, vl, vstart, pct;
        bit  vm;
        rst             = 1'b1;
        bus.start_valid = 1'b0;
        bus.out_ready   = 1'b0;
        bus.vl          = '0;
        bus.vstart      = '0;
        bus.sew         = SEW8;
        bus.lmul        = LMUL1;
        set_mask(1'b1, '0);
        repeat (3) @(negedge clk);
        check_quiet("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_ready", bus.start_ready, 1);

        run_cfg(4, 0, 2, 0, 1'b1, '0, 100, -1);     // SEW32 LMUL1
        run_cfg(20, 15, 0, 1, 1'b1, '0, 100, -1);   // SEW8 LMUL2, crosses register
        run_cfg(10, 0, 1, 7, 1'b1, '0, 100, -1);    // SEW16 LMULHALF -> cnt 4
        run_cfg(0, 0, 1, 0, 1'b1, '0, 100, -1);     // vl=0
        run_cfg(8, 8, 2, 1, 1'b1, '0, 100, -1);     // vstart == cnt
        run_cfg(16, 0, 3, 0, 1'b1, '0, 100, -1);    // SEW64
        run_cfg(16, 0, 0, 4, 1'b1, '0, 100, -1);    // reserved LMUL
        run_cfg(16, 0, 2, 5, 1'b1, '0, 100, -1);    // SEW32 LMULEIGHTH
        run_cfg(128, 0, 0, 3, 1'b1, '0, 100, -1);   // full 128-element group
        run_cfg(16, 2, 0, 0, 1'b1, '0, 100, 2);     // 3-cycle stall mid-sequence
        run_cfg(7, 0, 2, 1, 1'b1, '0, 50, 1);       // odd count with random stalls
`ifdef RV32V_SEQ_MASK_EN
        run_cfg(4, 0, 2, 0, 1'b0, 128'h5, 100, -1);
        run_cfg(32, 3, 0, 1, 1'b0, {$urandom, $urandom, $urandom, $urandom}, 70, -1);
`endif
        reset_mid_issue();
        run_cfg(6, 1, 2, 1, 1'b1, '0, 100, -1);     // recovery after reset

        for (int n = 0; n < 40; n++) begin
            sew    = ($urandom_range(0, 9) == 0) ? $urandom_range(3, 7) : $urandom_range(0, 2);
            lmul   = $urandom_range(0, 7);
            vl     = $urandom_range(0, 128);
            vstart = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 8);
            pct    = $urandom_range(30, 100);
`ifdef RV32V_SEQ_MASK_EN
            vm     = 1'($urandom_range(0, 1));
`else
            vm     = 1'b1;
`endif
            run_cfg(vl, vstart, sew, lmul, vm, {$urandom, $urandom, $urandom, $urandom}, pct, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
